// File: rtl/shift_wb_queue_if.sv
// Result handshake bundle between execute-stage result mux, queue and writeback.
// Latency: none, wires only.
// Backpressure: in_ready throttles the producer, out_ready throttles the queue.
interface shift_wb_queue_if #(
  parameter int DATA_W = 32
);
  // producer -> queue
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [4:0]        in_rd;
  logic              in_we;
  // queue -> writeback
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [4:0]        out_rd;
  logic              out_we;

  // Environment side: produces results and consumes the head.
  modport master (
    output in_valid, in_result, in_rd, in_we, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_we
  );

  // Queue side.
  modport slave (
    input  in_valid, in_result, in_rd, in_we, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_we
  );
endinterface

// File: rtl/shift_wb_queue.sv
// In-order result queue between shifter/ALU result mux and register writeback; optional
// forwarding lookup built when SHIFT_WB_FWD_EN is defined. Latency: push at edge N shows at head in cycle N+1.
// Backpressure: in_ready = count != DEPTH from registered state only; head holds while out_ready is low.
module shift_wb_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  shift_wb_queue_if.slave   bus,
  output logic [PTR_W:0]    count,
  input  logic [4:0]        fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [4:0]        rd;
    logic              we;
  } entry_t;

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             push;
  logic             pop;
  entry_t           head;
  entry_t           wr_entry;

  // Handshake qualifiers; ready depends only on registered occupancy, so a
  // full queue refuses a push even while it is popping.
  always_comb begin
    bus.in_ready  = (count_q != FULL);
    bus.out_valid = (count_q != '0);
    push          = bus.in_valid & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready;
  end

  // Entry formed from the producer; a write to r0 is queued but marked non-writing.
  always_comb begin
    wr_entry.result = bus.in_result;
    wr_entry.rd     = bus.in_rd;
    wr_entry.we     = bus.in_we & (bus.in_rd != 5'd0);
  end

  // Entry storage is never reset or flushed; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy; flush discards everything and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // Head presentation; zeros when empty so stale storage never leaks out.
  always_comb begin
    head           = mem[rd_ptr];
    bus.out_result = '0;
    bus.out_rd     = '0;
    bus.out_we     = 1'b0;
    if (bus.out_valid) begin
      bus.out_result = head.result;
      bus.out_rd     = head.rd;
      bus.out_we     = head.we;
    end
  end

  assign count = count_q;

`ifdef SHIFT_WB_FWD_EN
  // Forwarding: walk valid entries oldest to youngest so the youngest match
  // is the last one to overwrite the result. In-flight pushes are not seen.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PTR_W'(i);
        if (((PTR_W+1)'(i) < count_q) && mem[idx].we && (mem[idx].rd == fwd_rs)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem[idx].result;
        end
      end
    end
  end
`else
  logic unused_fwd_rs;

  // Forwarding not built: lookup outputs are constant zero and fwd_rs is ignored.
  always_comb begin
    fwd_hit       = 1'b0;
    fwd_data      = '0;
    unused_fwd_rs = ^fwd_rs;
  end
`endif

endmodule

// File: tb/tb_shift_wb_queue.sv
// Directed bench for shift_wb_queue with DEPTH = 2, DATA_W = 32.
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
// Forwarding expectations follow SHIFT_WB_FWD_EN (all zero when not built).
module tb_shift_wb_queue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int PTR_W  = 1;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [PTR_W:0]    count;
  logic [4:0]        fwd_rs;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  int checks;
  int errors;

  shift_wb_queue_if #(.DATA_W(DATA_W)) bus ();

  shift_wb_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus.slave),
    .count    (count),
    .fwd_rs   (fwd_rs),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Forwarding lookup; when the feature is not built the outputs must stay zero.
  task automatic chk_fwd(input string tag, input logic hit_exp, input logic [31:0] data_exp);
`ifdef SHIFT_WB_FWD_EN
    chk({tag, "_hit"},  64'(fwd_hit),  64'(hit_exp));
    chk({tag, "_data"}, 64'(fwd_data), 64'(data_exp));
`else
    chk({tag, "_hit"},  64'(fwd_hit),  64'(1'b0 & hit_exp));
    chk({tag, "_data"}, 64'(fwd_data), 64'(32'h0 & data_exp));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] res, input logic [4:0] rd, input logic we);
    bus.in_valid  = v;
    bus.in_result = res;
    bus.in_rd     = rd;
    bus.in_we     = we;
  endtask

  task automatic chk_head(input string tag, input logic vld, input logic [31:0] res,
                          input logic [4:0] rd, input logic we, input int cnt);
    chk({tag, "_vld"},   64'(bus.out_valid),  64'(vld));
    chk({tag, "_res"},   64'(bus.out_result), 64'(res));
    chk({tag, "_rd"},    64'(bus.out_rd),     64'(rd));
    chk({tag, "_we"},    64'(bus.out_we),     64'(we));
    chk({tag, "_count"}, 64'(count),          64'(cnt));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    fwd_rs        = 5'd0;
    bus.out_ready = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 1'b0);

    // Reset state
    #12;
    chk_head("rst", 1'b0, 32'h0, 5'd0, 1'b0, 0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk_fwd("rst_fwd", 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First push: no same-cycle bypass, visible after the edge
    offer(1'b1, 32'h8000_0000, 5'd3, 1'b1);
    #1;
    chk("nobypass_vld", 64'(bus.out_valid), 64'd0);
    step();
    offer(1'b0, 32'h0, 5'd0, 1'b0);
    chk_head("p1", 1'b1, 32'h8000_0000, 5'd3, 1'b1, 1);
    fwd_rs = 5'd3;
    #1;
    chk_fwd("p1_fwd", 1'b1, 32'h8000_0000);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk_head("p1_pop", 1'b0, 32'h0, 5'd0, 1'b0, 0);
    chk_fwd("p1_pop_fwd", 1'b0, 32'h0);

    // Fill to DEPTH, third push refused
    offer(1'b1, 32'h11, 5'd1, 1'b1);
    step();
    offer(1'b1, 32'h22, 5'd2, 1'b1);
    step();
    offer(1'b1, 32'h33, 5'd4, 1'b1);
    #1;
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk_head("full", 1'b1, 32'h11, 5'd1, 1'b1, 2);
    step();
    chk_head("full_hold", 1'b1, 32'h11, 5'd1, 1'b1, 2);
    // Full with pop and offered push: only the pop happens
    bus.out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk_head("pop_only", 1'b1, 32'h22, 5'd2, 1'b1, 1);
    chk("pop_only_in_ready", 64'(bus.in_ready), 64'd1);
    // Push and pop together across the pointer wrap
    step();
    offer(1'b0, 32'h0, 5'd0, 1'b0);
    chk_head("wrap", 1'b1, 32'h33, 5'd4, 1'b1, 1);
    step();
    bus.out_ready = 1'b0;
    chk_head("drain", 1'b0, 32'h0, 5'd0, 1'b0, 0);

    // Forwarding priority: youngest matching entry wins
    offer(1'b1, 32'hA, 5'd5, 1'b1);
    step();
    offer(1'b1, 32'hB, 5'd5, 1'b1);
    step();
    offer(1'b0, 32'h0, 5'd0, 1'b0);
    fwd_rs = 5'd5;
    #1;
    chk_fwd("young", 1'b1, 32'hB);
    fwd_rs = 5'd0;
    #1;
    chk_fwd("rs0", 1'b0, 32'h0);
    // Pop A; then the entry being pushed is not yet visible
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk_head("popA", 1'b1, 32'hB, 5'd5, 1'b1, 1);
    offer(1'b1, 32'h77, 5'd7, 1'b1);
    fwd_rs = 5'd7;
    #1;
    chk_fwd("inflight", 1'b0, 32'h0);
    step();
    offer(1'b0, 32'h0, 5'd0, 1'b0);
    chk_fwd("landed", 1'b1, 32'h77);

    // Flush with push asserted while full: everything discarded
    flush = 1'b1;
    offer(1'b1, 32'h99, 5'd9, 1'b1);
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 1'b0);
    chk_head("flush", 1'b0, 32'h0, 5'd0, 1'b0, 0);
    chk_fwd("flush_fwd", 1'b0, 32'h0);
    // Flush with room: the simultaneous push is also dropped
    offer(1'b1, 32'h55, 5'd8, 1'b1);
    step();
    flush = 1'b1;
    offer(1'b1, 32'h66, 5'd9, 1'b1);
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 1'b0);
    step();
    chk_head("flush_push", 1'b0, 32'h0, 5'd0, 1'b0, 0);

    // we = 0 entry and r0 write never forward and never write
    offer(1'b1, 32'hC, 5'd6, 1'b0);
    step();
    offer(1'b1, 32'hD, 5'd0, 1'b1);
    step();
    offer(1'b0, 32'h0, 5'd0, 1'b0);
    fwd_rs = 5'd6;
    #1;
    chk_fwd("we0", 1'b0, 32'h0);
    chk_head("we0_head", 1'b1, 32'hC, 5'd6, 1'b0, 2);
    fwd_rs = 5'd0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk_head("r0_head", 1'b1, 32'hD, 5'd0, 1'b0, 1);
    chk_fwd("r0_fwd", 1'b0, 32'h0);

    // Asynchronous reset mid-pop clears outputs immediately
    offer(1'b1, 32'hE, 5'd10, 1'b1);
    fwd_rs = 5'd10;
    step();
    offer(1'b0, 32'h0, 5'd0, 1'b0);
    chk_head("pre_rst", 1'b1, 32'hD, 5'd0, 1'b0, 2);
    chk_fwd("pre_rst_fwd", 1'b1, 32'hE);
    bus.out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_head("mid_rst", 1'b0, 32'h0, 5'd0, 1'b0, 0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk_fwd("mid_rst_fwd", 1'b0, 32'h0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_head("post_rst", 1'b0, 32'h0, 5'd0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
